ksa_multikey: RTL and testbench
===============================

// Module: ksa_multikey
// PURPOSE
//  RC4 key-scheduling engine, parametrised in key length and memory read latency.
//  Permutes a 256x8 S-box held in an external single-port RAM through an addr/rddata/wrdata/wren port.
//  Sits between the S-box init stage and the PRGA stage of the decrypt datapath.
//  Started by an en/rdy handshake.
// PARAMETERS
//  KEY_BYTES  3  max key length in bytes (1..32); key bus is 8*KEY_BYTES wide
//  RD_LAT     1  RAM read latency in cycles (1 or 2): addr at cycle t -> rddata valid at t+RD_LAT
// PORTS
//  clk      in   1              clock, all logic on posedge
//  rst_n    in   1              synchronous active-low reset
//  en       in   1              start request, sampled only while rdy=1
//  rdy      out  1              idle/ready
//  key      in   8*KEY_BYTES    key, byte 0 = MS byte key[8*KEY_BYTES-1 -:8]
//  keylen   in   6              active key bytes, 1..KEY_BYTES (0 or >KEY_BYTES clamps to KEY_BYTES)
//  addr     out  8              RAM address
//  rddata   in   8              RAM read data
//  wrdata   out  8              RAM write data
//  wren     out  1              RAM write enable
// BEHAVIOUR
//  - Reset: rst_n low at a posedge -> state IDLE; i, j, kidx cleared.
//    From the next cycle: rdy=1, wren=0, addr=0, wrdata=0.
//    Reset mid-run abandons the run; the RAM is left partially permuted.
//  - Handshake: en=1 in an IDLE cycle accepts a run.
//    key and clamped keylen are latched on that edge; rdy=0 from the next cycle until done.
//    en while rdy=0 is ignored.
//  - Algorithm, for i=0..255:
//    j = (j + S[i] + K[kidx]) mod 256; swap S[i], S[j].
//    kidx wraps from keylen-1 to 0; no modulo divider.
//    All sums are 8-bit with carry discarded.
//  - States:
//    IDLE -> [INIT] -> RI -> (WI_WAIT x RD_LAT-1) -> CJ -> RJ -> (WJ_WAIT x RD_LAT-1) -> WI -> WJ -> RI | IDLE
//    RI: addr=i. CJ: si<=rddata, j<=j+rddata+K[kidx], addr=j.
//    RJ: addr=j. WI: sj<=rddata, wren=1, addr=i, wrdata=rddata.
//    WJ: wren=1, addr=j, wrdata=si. Then i++, kidx advances.
//    After WJ with i=255: go to IDLE; rdy=1 the following cycle.
//  - Wait states hold addr. wren=0 in every state except WI, WJ (and INIT).
//  - Cost: 3+2*RD_LAT cycles per iteration; 256*(3+2*RD_LAT) busy cycles per run.
//  - i==j: both writes target the same address; final S[i] = original S[i] (correct swap).
//  - Reads of S[j] always follow the prior iteration's writes, so no RAM hazard.
//  - Keys are sampled only at acceptance; key/keylen changes mid-run have no effect.
// CONFIGURATION
//  KSA_INIT_PASS_EN defined:
//    Before RI, state INIT writes S[i]=i for i=0..255: wren=1, addr=i, wrdata=i, 1 cycle each.
//    Adds 256 busy cycles.
//  Undefined:
//    INIT is absent; the RAM must already hold the identity S-box; run starts at RI.
// TESTING
//  T1 RD_LAT=1, identity S, key=24'h0A0000, keylen=3:
//     first writes are addr0<=8'h0A then addr10<=8'h00.
//     rdy low exactly 1280 cycles; final S matches the software RC4 KSA model.
//  T2 KEY_BYTES=3, keylen=1, key=24'h01FFFF:
//     final S equals the model for single-byte key 8'h01; bytes 1-2 never used.
//  T3 keylen=0 and keylen=9 with KEY_BYTES=3:
//     both give S identical to the keylen=3 run.
//  T4 RD_LAT=2, RAM model with 2-cycle latency:
//     rdy low 1792 cycles; S matches the model.
//     en pulsed mid-run has no effect on timing or RAM.
//  T5 rst_n low for 1 cycle during iteration 100:
//     next cycle rdy=1, wren=0, addr=0.
//     A fresh en starts with i=0, j=0, kidx=0.
//  T6 KSA_INIT_PASS_EN, garbage-filled RAM, key=24'h000000:
//     first 256 cycles wren=1, addr=wrdata=0..255.
//     Total busy 1536 cycles; S matches the model.

Source files
------------

// File: rtl/ksa_multikey.sv
// rtl/ksa_multikey.sv - RC4 key-scheduling engine permuting an external 256x8 S-box RAM
// Optional identity-fill pass before scheduling: define KSA_INIT_PASS_EN.
module ksa_multikey #(
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [5:0]             keylen,
    output logic [7:0]             addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_RI, S_WI_WAIT, S_CJ, S_RJ, S_WJ_WAIT, S_WI, S_WJ
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             i_q, i_d, j_q, j_d, si_q, si_d;
    logic [4:0]             kidx_q, kidx_d;
    logic [5:0]             len_q, len_d, len_clamped;
    logic [8*KEY_BYTES-1:0] key_q, key_d, key_sh;
    logic [7:0]             kbyte;

    assign len_clamped = (keylen == 6'd0 || keylen > 6'(KEY_BYTES)) ? 6'(KEY_BYTES) : keylen;
    // Byte 0 is the MS byte, so shifting left by kidx bytes brings K[kidx] to the top.
    assign key_sh = key_q << {kidx_q, 3'b000};
    assign kbyte  = key_sh[8*KEY_BYTES-1 -: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q    <= 8'd0;
            j_q    <= 8'd0;
            kidx_q <= 5'd0;
            si_q   <= 8'd0;
            len_q  <= 6'd0;
            key_q  <= '0;
        end else begin
            i_q    <= i_d;
            j_q    <= j_d;
            kidx_q <= kidx_d;
            si_q   <= si_d;
            len_q  <= len_d;
            key_q  <= key_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
`ifdef KSA_INIT_PASS_EN
                    state_d = S_INIT;
`else
                    state_d = S_RI;
`endif
                end
            end
            S_INIT:    if (i_q == 8'hFF) state_d = S_RI;
            S_RI:      state_d = (RD_LAT > 1) ? S_WI_WAIT : S_CJ;
            S_WI_WAIT: state_d = S_CJ;
            S_CJ:      state_d = S_RJ;
            S_RJ:      state_d = (RD_LAT > 1) ? S_WJ_WAIT : S_WI;
            S_WJ_WAIT: state_d = S_WI;
            S_WI:      state_d = S_WJ;
            S_WJ:      state_d = (i_q == 8'hFF) ? S_IDLE : S_RI;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        i_d    = i_q;
        j_d    = j_q;
        kidx_d = kidx_q;
        si_d   = si_q;
        len_d  = len_q;
        key_d  = key_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    i_d    = 8'd0;
                    j_d    = 8'd0;
                    kidx_d = 5'd0;
                    len_d  = len_clamped;
                    key_d  = key;
                end
            end
            S_INIT: i_d = i_q + 8'd1;
            S_CJ: begin
                si_d = rddata;
                j_d  = j_q + rddata + kbyte;
            end
            S_WJ: begin
                i_d    = i_q + 8'd1;
                kidx_d = ({1'b0, kidx_q} == len_q - 6'd1) ? 5'd0 : kidx_q + 5'd1;
            end
            default: ;
        endcase
    end

    // WI writes S[j] into slot i straight from the read port; WJ writes the saved S[i].
    always_comb begin
        rdy    = 1'b0;
        addr   = 8'd0;
        wrdata = 8'd0;
        wren   = 1'b0;
        case (state_q)
            S_IDLE: rdy = 1'b1;
            S_INIT: begin
                wren   = 1'b1;
                addr   = i_q;
                wrdata = i_q;
            end
            S_RI, S_WI_WAIT:       addr = i_q;
            S_CJ, S_RJ, S_WJ_WAIT: addr = j_q;
            S_WI: begin
                wren   = 1'b1;
                addr   = i_q;
                wrdata = rddata;
            end
            S_WJ: begin
                wren   = 1'b1;
                addr   = j_q;
                wrdata = si_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ksa_multikey.sv
// tb/tb_ksa_multikey.sv - randomized self-checking bench for ksa_multikey at RD_LAT 1 and 2
// Honours KSA_INIT_PASS_EN when the build defines it.
module tb_ksa_multikey;
`ifdef KSA_INIT_PASS_EN
    localparam int NINIT = 256;
`else
    localparam int NINIT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en     [2];
    logic        rdy    [2];
    logic [23:0] key    [2];
    logic [5:0]  keylen [2];
    logic [7:0]  addr   [2];
    logic [7:0]  wrdata [2];
    logic        wren   [2];
    logic        load   [2];
    logic [7:0]  rdd0, rdd1, rd1_p;
    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic [7:0]  pre  [256];
    logic [7:0]  exp_s [256];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    ksa_multikey #(.KEY_BYTES(3), .RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key[0]), .keylen(keylen[0]),
        .addr(addr[0]), .rddata(rdd0), .wrdata(wrdata[0]), .wren(wren[0])
    );

    ksa_multikey #(.KEY_BYTES(3), .RD_LAT(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key[1]), .keylen(keylen[1]),
        .addr(addr[1]), .rddata(rdd1), .wrdata(wrdata[1]), .wren(wren[1])
    );

    always @(posedge clk) begin
        if (load[0]) begin
            for (int k = 0; k < 256; k++) mem0[k] <= pre[k];
        end else if (wren[0]) begin
            mem0[addr[0]] <= wrdata[0];
        end
        rdd0 <= mem0[addr[0]];
    end

    always @(posedge clk) begin
        if (load[1]) begin
            for (int k = 0; k < 256; k++) mem1[k] <= pre[k];
        end else if (wren[1]) begin
            mem1[addr[1]] <= wrdata[1];
        end
        rd1_p <= mem1[addr[1]];
        rdd1  <= rd1_p;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [7:0] memrd(input int w, input int k);
        return (w == 0) ? mem0[k] : mem1[k];
    endfunction

    // Textbook RC4 KSA on an identity S-box, key byte chosen by i mod keylen.
    task automatic model(input logic [23:0] k, input logic [5:0] kl);
        int         n, j, kli;
        logic [7:0] t, kb;
        kli = int'(kl);
        n = (kli == 0 || kli > 3) ? 3 : kli;
        for (int x = 0; x < 256; x++) exp_s[x] = 8'(x);
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kb = 8'(k >> (8 * (2 - (x % n))));
            j = (j + int'(exp_s[x]) + int'(kb)) % 256;
            t = exp_s[x];
            exp_s[x] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic run(input int w, input logic [23:0] k, input logic [5:0] kl,
                       input bit pulse_mid, input int rst_at,
                       output int busy, output int nbad, output int init_bad,
                       output logic [15:0] wr0, output logic [15:0] wr1);
        int nw;
        busy = 0; nbad = 0; init_bad = 0; nw = 0; wr0 = 16'd0; wr1 = 16'd0;
        for (int n = 0; n < 256; n++) pre[n] = (NINIT != 0) ? 8'($urandom) : 8'(n);
        @(negedge clk); load[w] = 1'b1;
        @(negedge clk); load[w] = 1'b0;
        model(k, kl);
        key[w] = k; keylen[w] = kl; en[w] = 1'b1;
        @(negedge clk);
        en[w] = 1'b0;
        key[w] = 24'($urandom);
        keylen[w] = 6'($urandom_range(0, 9));
        while (!rdy[w] && busy < 4000) begin
            if (busy < NINIT) begin
                if (!(wren[w] && addr[w] == 8'(busy) && wrdata[w] == 8'(busy))) init_bad++;
            end else if (wren[w]) begin
                if (nw == 0) wr0 = {addr[w], wrdata[w]};
                if (nw == 1) wr1 = {addr[w], wrdata[w]};
                nw++;
            end
            busy++;
            en[w] = (pulse_mid && busy == 600);
            if (busy == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("rst_mid_rdy", 32'(rdy[w]), 32'd1);
                chk("rst_mid_wren", 32'(wren[w]), 32'd0);
                chk("rst_mid_addr", 32'(addr[w]), 32'd0);
                rst_n = 1'b1;
                en[w] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        en[w] = 1'b0;
        for (int n = 0; n < 256; n++) if (memrd(w, n) !== exp_s[n]) nbad++;
    endtask

    initial begin
        int          busy, nbad, ibad, w, lat;
        logic [15:0] w0, w1;
        logic [23:0] k;
        logic [5:0]  kl;
        rst_n = 1'b0;
        for (int q = 0; q < 2; q++) begin
            en[q] = 1'b0; key[q] = 24'd0; keylen[q] = 6'd0; load[q] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int q = 0; q < 2; q++) begin
            chk("reset_rdy", 32'(rdy[q]), 32'd1);
            chk("reset_wren", 32'(wren[q]), 32'd0);
            chk("reset_addr", 32'(addr[q]), 32'd0);
            chk("reset_wrdata", 32'(wrdata[q]), 32'd0);
        end

        run(0, 24'h0A0000, 6'd3, 1'b0, -1, busy, nbad, ibad, w0, w1);
        chk("t1_first_write", 32'(w0), 32'h000A);
        chk("t1_second_write", 32'(w1), 32'h0A00);
        chk("t1_busy", 32'(busy), 32'(1280 + NINIT));
        chk("t1_sbox", 32'(nbad), 32'd0);
        chk("t1_init", 32'(ibad), 32'd0);

        run(0, 24'h01FFFF, 6'd1, 1'b0, -1, busy, nbad, ibad, w0, w1);
        chk("t2_busy", 32'(busy), 32'(1280 + NINIT));
        chk("t2_sbox", 32'(nbad), 32'd0);

        k = 24'($urandom);
        run(0, k, 6'd0, 1'b0, -1, busy, nbad, ibad, w0, w1);
        chk("t3_len0_sbox", 32'(nbad), 32'd0);
        run(1, k, 6'd9, 1'b0, -1, busy, nbad, ibad, w0, w1);
        chk("t3_len9_sbox", 32'(nbad), 32'd0);

        run(1, 24'($urandom), 6'd3, 1'b1, -1, busy, nbad, ibad, w0, w1);
        chk("t4_busy", 32'(busy), 32'(1792 + NINIT));
        chk("t4_sbox", 32'(nbad), 32'd0);
        chk("t4_init", 32'(ibad), 32'd0);

        run(0, 24'($urandom), 6'd3, 1'b0, NINIT + 100 * 5 + 2, busy, nbad, ibad, w0, w1);
        run(0, 24'h5A3C11, 6'd2, 1'b0, -1, busy, nbad, ibad, w0, w1);
        chk("t5_after_rst_busy", 32'(busy), 32'(1280 + NINIT));
        chk("t5_after_rst_sbox", 32'(nbad), 32'd0);

        for (int r = 0; r < 6; r++) begin
            w   = r % 2;
            lat = w + 1;
            k   = 24'($urandom);
            kl  = 6'($urandom_range(0, 9));
            run(w, k, kl, r[1], -1, busy, nbad, ibad, w0, w1);
            chk("rand_busy", 32'(busy), 32'(256 * (3 + 2 * lat) + NINIT));
            chk("rand_sbox", 32'(nbad), 32'd0);
            chk("rand_init", 32'(ibad), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
